regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port among NREQ requesters
//  (e.g. ALU writeback, load unit, link-register write).
//  Round-robin arbitration; registered wr_en/wr_addr/wr_data drive the
//  5-to-32 write decoder enable/select and the data bus directly.
//  Writes to the zero register (address 31) are acknowledged but never
//  committed.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  ADDR_W  5   register address width (32 registers)
//  DATA_W  64  write data width
//  ZERO_REG 31 address of hard-wired zero register; writes suppressed
// PORTS
//  clk       in   1             single clock, rising edge
//  reset_n   in   1             asynchronous, active-low reset
//  req       in   NREQ          req[i]=1: requester i has a pending write
//  req_addr  in   NREQ*ADDR_W   slice i = target register of requester i
//  req_data  in   NREQ*DATA_W   slice i = write data of requester i
//  gnt       out  NREQ          one-hot, 1-cycle pulse: request accepted
//  wr_en     out  1             register-file write enable (decoder enable)
//  wr_addr   out  ADDR_W        register-file write select
//  wr_data   out  DATA_W        register-file write data
//  busy      out  1             1 when any req is high this cycle (comb)
// BEHAVIOUR
//  - Reset (reset_n=0, async): gnt=0, wr_en=0, wr_addr=0, wr_data=0,
//    rr_ptr=0; takes effect immediately, mid-cycle; no partial write.
//  - Eligible set E = req & ~gnt (requester granted last cycle is masked
//    for one cycle so it can drop req without a double grant).
//  - Winner w = first i in E scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//  - Edge after a cycle with E!=0: gnt<=onehot(w); wr_addr<=req_addr[w];
//    wr_data<=req_data[w]; wr_en<=(req_addr[w]!=ZERO_REG);
//    rr_ptr<=(w+1) mod NREQ.
//  - E==0: gnt<=0, wr_en<=0, wr_addr/wr_data hold, rr_ptr holds.
//  - Latency: req sampled cycle N -> gnt and wr_en high cycle N+1;
//    register file captures on edge ending N+1.
//  - Handshake: requester holds req/addr/data stable until it sees gnt;
//    deasserts req (or presents next write) in the cycle gnt is high.
//  - Throughput: one write per cycle total; a single requester gets at
//    most one write every 2 cycles; with k>=2 active requesters, each
//    is served within NREQ cycles (no starvation).
//  - ZERO_REG write: gnt pulses, rr_ptr advances, wr_en stays 0.
//  - Two requesters targeting same register in consecutive cycles: both
//    commit in grant order; last grant wins. No address coalescing.
//  - rr_ptr wraps NREQ-1 -> 0.
// CONFIGURATION
//  REGFILE_ARB_WRCNT_EN defined: extra output wr_count[15:0]; increments
//    on each edge where wr_en is asserted by the arbiter (committed
//    writes only, not ZERO_REG grants); saturates at 16'hFFFF; reset 0.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: hold reset_n=0, req=4'hF -> gnt=0, wr_en=0; release ->
//    first grant gnt=4'b0001 one cycle later.
//  2 Single: req=4'b0100, addr=5, data=64'hDEAD -> next cycle gnt=0100,
//    wr_en=1, wr_addr=5, wr_data=DEAD; req dropped -> wr_en=0 next cycle.
//  3 Round robin: req=4'hF held, addr_i=i+1 -> gnt sequence 0001,0010,
//    0100,1000,0001; wr_addr 1,2,3,4,1.
//  4 Zero reg: req=4'b0001, addr=31 -> gnt=0001, wr_en=0; wr_count
//    unchanged (with REGFILE_ARB_WRCNT_EN).
//  5 Async reset mid-grant: assert reset_n=0 while wr_en=1 -> wr_en,gnt
//    drop before next clk edge; rr_ptr restarts at 0.
//  6 Saturation (REGFILE_ARB_WRCNT_EN): 65540 committed writes ->
//    wr_count=16'hFFFF, stays there.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter sharing the single register-file write port among
// NREQ requesters. The winning request is registered straight onto
// wr_en/wr_addr/wr_data, which feed the write decoder and data bus.
// Writes aimed at the hard-wired zero register are granted but never
// committed: gnt pulses while wr_en stays low.
//
// Build option: define REGFILE_ARB_WRCNT_EN to add wr_count[15:0], a
// saturating count of committed writes. Without it the port and the
// counter do not exist and everything else behaves identically.
module regfile_write_arbiter #(
  parameter int NREQ     = 4,   // number of requesters (2..8)
  parameter int ADDR_W   = 5,   // register address width
  parameter int DATA_W   = 64,  // write data width
  parameter int ZERO_REG = 31   // hard-wired zero register address
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy
`ifdef REGFILE_ARB_WRCNT_EN
  ,
  output logic [15:0]              wr_count
`endif
);

  localparam int                PTR_W     = $clog2(NREQ);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  nxt_ptr;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   win_onehot;
  logic              win_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // The requester granted last cycle sits out one cycle so it can drop
  // req in its grant cycle without being granted twice.
  assign eligible = req & ~gnt;

  // busy reflects the raw request lines, not the registered grant.
  assign busy = |req;

  // Scan eligible requesters starting at rr_ptr; first hit wins.
  always_comb begin
    // NOTE: every variable gets a default before the scan, so no path
    // through the loop leaves one unassigned and no latch is inferred.
    int idx;
    win_valid  = 1'b0;
    win_onehot = '0;
    win_addr   = '0;
    win_data   = '0;
    nxt_ptr    = rr_ptr;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_valid && eligible[idx]) begin
        win_valid       = 1'b1;
        win_onehot[idx] = 1'b1;
        win_addr        = req_addr[idx*ADDR_W +: ADDR_W];
        win_data        = req_data[idx*DATA_W +: DATA_W];
        nxt_ptr         = (idx == NREQ - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  // Register the winner onto the write port and advance the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      gnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_ptr  <= '0;
    end else if (win_valid) begin
      gnt     <= win_onehot;
      wr_addr <= win_addr;
      wr_data <= win_data;
      wr_en   <= (win_addr != ZERO_ADDR);
      rr_ptr  <= nxt_ptr;
    end else begin
      // Idle: address and data hold, only the strobes drop.
      gnt   <= '0;
      wr_en <= 1'b0;
    end
  end

`ifdef REGFILE_ARB_WRCNT_EN
  // Count edges on which the register file actually commits a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
    end else if (wr_en && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Self-checking bench for regfile_write_arbiter. Requester agents drive
// a handshake-compliant request stream; a reference model predicts the
// registered write port for each cycle and queues it, and a monitor
// compares the queue against the DUT one cycle later. Compile with
// REGFILE_ARB_WRCNT_EN to include the write-counter checks.
module tb_regfile_write_arbiter;

  localparam int NREQ     = 4;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int ZERO_REG = 31;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   busy;
`ifdef REGFILE_ARB_WRCNT_EN
  logic [15:0]            wr_count;
`endif

  regfile_write_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
`ifdef REGFILE_ARB_WRCNT_EN
    , .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]   gnt;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic [15:0]       cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: what the write port should show after the next edge.
  logic [NREQ-1:0]   m_gnt;
  int                m_rr;
  logic              m_wren;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_cnt;

  // Requester agents.
  bit                pend   [NREQ];
  logic [ADDR_W-1:0] a_addr [NREQ];
  logic [DATA_W-1:0] a_data [NREQ];
  bit                rand_mode;
  logic [NREQ-1:0]   hold_mask;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt  = '0;
    m_rr   = 0;
    m_wren = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_cnt  = 0;
  endtask

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    a_addr[i] = ($urandom_range(0, 5) == 0) ? ADDR_W'(ZERO_REG)
                                            : ADDR_W'($urandom_range(0, 31));
    a_data[i] = {$urandom, $urandom};
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]                       = pend[i];
      req_addr[i*ADDR_W +: ADDR_W] = a_addr[i];
      req_data[i*DATA_W +: DATA_W] = a_data[i];
    end
  endtask

  // One cycle of stimulus, issued just after a falling edge: agents react
  // to the grant they can see, then the model predicts the next edge.
  task automatic step();
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] elig;
    int              w;
    exp_t            e;
    for (int i = 0; i < NREQ; i++) begin
      if (m_gnt[i]) begin
        if (rand_mode) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else pend[i] = 1'b0;
        end else if (!hold_mask[i]) begin
          pend[i] = 1'b0;
        end
      end else if (rand_mode && !pend[i] && $urandom_range(0, 9) < 3) begin
        new_req(i);
      end
    end
    drive();
    for (int i = 0; i < NREQ; i++) r[i] = pend[i];
    elig = r & ~m_gnt;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && elig[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
    end
    e.busy = |r;
    if (m_wren && m_cnt < 65535) m_cnt++;
    if (w >= 0) begin
      m_gnt    = '0;
      m_gnt[w] = 1'b1;
      m_addr   = a_addr[w];
      m_data   = a_data[w];
      m_wren   = (a_addr[w] != ADDR_W'(ZERO_REG));
      m_rr     = (w + 1) % NREQ;
    end else begin
      m_gnt  = '0;
      m_wren = 1'b0;
    end
    e.gnt   = m_gnt;
    e.wr_en = m_wren;
    e.addr  = m_addr;
    e.data  = m_data;
    e.cnt   = 16'(m_cnt);
    sb.push_back(e);
  endtask

  // Monitor: one predicted entry per issued cycle, checked after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_gnt",   64'(gnt),     64'(e.gnt));
      check("sb_wr_en", 64'(wr_en),   64'(e.wr_en));
      check("sb_addr",  64'(wr_addr), 64'(e.addr));
      check("sb_data",  wr_data,      e.data);
      check("sb_busy",  64'(busy),    64'(e.busy));
`ifdef REGFILE_ARB_WRCNT_EN
      check("sb_count", 64'(wr_count), 64'(e.cnt));
`endif
    end
  end

  initial begin
    logic [NREQ-1:0]   rr_gnt  [5];
    logic [ADDR_W-1:0] rr_addr [5];
    rr_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};

    reset_n   = 1'b0;
    rand_mode = 1'b0;
    hold_mask = '0;
    model_reset();

    // Reset held with every requester asserted.
    for (int i = 0; i < NREQ; i++) begin
      pend[i]   = 1'b1;
      a_addr[i] = ADDR_W'(i + 1);
      a_data[i] = 64'h1111_0000_0000_0000 * (i + 1) + 64'(i);
    end
    drive();
    repeat (2) @(negedge clk);
    check("rst_gnt",   64'(gnt),     64'd0);
    check("rst_wr_en", 64'(wr_en),   64'd0);
    check("rst_addr",  64'(wr_addr), 64'd0);
    check("rst_data",  wr_data,      64'd0);

    // Release with req=F held: round robin from requester 0.
    reset_n   = 1'b1;
    hold_mask = '1;
    step();
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #2;
      check("rr_gnt",  64'(gnt),     64'(rr_gnt[j]));
      check("rr_addr", 64'(wr_addr), 64'(rr_addr[j]));
      @(negedge clk);
      if (j == 4) hold_mask = '0;
      step();
    end
    repeat (8) begin @(negedge clk); step(); end

    // Single requester; drops req in its grant cycle.
    @(negedge clk);
    pend[2] = 1'b1; a_addr[2] = 5'd5; a_data[2] = 64'hDEAD;
    step();
    @(posedge clk); #2;
    check("single_gnt",   64'(gnt),     64'b0100);
    check("single_wr_en", 64'(wr_en),   64'd1);
    check("single_addr",  64'(wr_addr), 64'd5);
    check("single_data",  wr_data,      64'hDEAD);
    @(negedge clk); step();
    @(posedge clk); #2;
    check("single_drop_wr_en", 64'(wr_en), 64'd0);
    check("single_hold_addr",  64'(wr_addr), 64'd5);

    // Zero register: granted, not committed.
    @(negedge clk);
    pend[0] = 1'b1; a_addr[0] = ADDR_W'(ZERO_REG); a_data[0] = 64'hBEEF;
    step();
    @(posedge clk); #2;
    check("zero_gnt",   64'(gnt),   64'b0001);
    check("zero_wr_en", 64'(wr_en), 64'd0);
    @(negedge clk); step();

    // Async reset in the middle of a committed grant.
    @(negedge clk);
    pend[1] = 1'b1; a_addr[1] = 5'd7; a_data[1] = 64'h7777;
    step();
    @(posedge clk); #2;
    check("pre_rst_wr_en", 64'(wr_en), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_gnt",   64'(gnt),   64'd0);
    check("async_rst_wr_en", 64'(wr_en), 64'd0);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    pend[1] = 1'b1; a_addr[1] = 5'd9;  a_data[1] = 64'h9;
    pend[3] = 1'b1; a_addr[3] = 5'd10; a_data[3] = 64'hA;
    step();
    @(posedge clk); #2;
    check("rr_restart_gnt", 64'(gnt), 64'b0010);
    repeat (4) begin @(negedge clk); step(); end

    // Randomised traffic.
    rand_mode = 1'b1;
    repeat (3000) begin @(negedge clk); step(); end
    rand_mode = 1'b0;
    repeat (12) begin @(negedge clk); step(); end

`ifdef REGFILE_ARB_WRCNT_EN
    // Two requesters alternating: one committed write per cycle.
    @(negedge clk);
    pend[0] = 1'b1; a_addr[0] = 5'd1; a_data[0] = 64'h1;
    pend[1] = 1'b1; a_addr[1] = 5'd2; a_data[1] = 64'h2;
    hold_mask = 4'b0011;
    step();
    repeat (65545) begin @(negedge clk); step(); end
    hold_mask = '0;
    repeat (6) begin @(negedge clk); step(); end
    @(posedge clk); #2;
    check("count_saturated", 64'(wr_count), 64'hFFFF);
`endif

    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
